// File: rtl/bus_sel_rr_interconnect.sv
// bus_sel_rr_interconnect
// N frame distributors (fd) by N output FIFOs. Every FIFO runs its own
// round-robin arbiter that locks onto one requesting fd and drives a one-hot
// select. The same lock is reported back to the fds as a transposed grant.
// An optional hold limit forces rotation when another fd is waiting.
module bus_sel_rr_interconnect #(
  parameter int PORT_NUM = 6,
  parameter int MAX_HOLD = 0,
  parameter int CNT_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PORT_NUM*PORT_NUM-1:0] fd_bus_req,
  output logic [PORT_NUM*PORT_NUM-1:0] fd_bus_grant,
  output logic [PORT_NUM*PORT_NUM-1:0] fifo_bus_sel,
  output logic [PORT_NUM-1:0]          fifo_busy
);

  localparam int N     = PORT_NUM;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Last counter value before preemption, and the saturation ceiling.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  for (genvar y = 0; y < N; y++) begin : g_fifo
    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [N-1:0]     req_col;
    logic [N-1:0]     sel_row;
    logic [IDX_W-1:0] pick;
    logic [IDX_W:0]   cand;
    logic             any_req;
    logic             others_req;
    logic             hold_expired;
    logic [IDX_W-1:0] owner_next;

    // Collect the requests aimed at this FIFO, one bit per fd.
    always_comb begin
      req_col = '0;
      for (int x = 0; x < N; x++) begin
        req_col[x] = fd_bus_req[x*N + y];
      end
    end

    // Round-robin search starting at rr_ptr, wrapping modulo N.
    always_comb begin
      any_req = 1'b0;
      pick    = '0;
      cand    = '0;
      for (int i = 0; i < N; i++) begin
        cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
        if (cand >= (IDX_W+1)'(N)) begin
          cand = cand - (IDX_W+1)'(N);
        end
        if (!any_req && req_col[cand[IDX_W-1:0]]) begin
          any_req = 1'b1;
          pick    = cand[IDX_W-1:0];
        end
      end
    end

    // Preemption and rotation helpers derived from the current owner.
    always_comb begin
      others_req   = |(req_col & ~(N'(1) << owner));
      hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
      owner_next   = (owner == IDX_W'(N - 1)) ? '0 : owner + 1'b1;
    end

    // Per-FIFO lock FSM: acquire an owner, hold it, release or get preempted.
    always_ff @(posedge clk) begin
      if (rst) begin
        state    <= IDLE;
        owner    <= '0;
        rr_ptr   <= '0;
        hold_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (any_req) begin
              owner    <= pick;
              hold_cnt <= '0;
              state    <= LOCKED;
            end
          end
          LOCKED: begin
            if (!req_col[owner]) begin
              state  <= IDLE;
              rr_ptr <= owner_next;
            end else if (hold_expired && others_req) begin
              state  <= IDLE;
              rr_ptr <= owner_next;
            end else if (hold_cnt != HOLD_MAX) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign sel_row                = (state == LOCKED) ? (N'(1) << owner) : '0;
    assign fifo_bus_sel[y*N +: N] = sel_row;
    assign fifo_busy[y]           = (state == LOCKED);

    for (genvar x = 0; x < N; x++) begin : g_grant
      assign fd_bus_grant[x*N + y] = sel_row[x];
    end
  end

endmodule

// File: tb/tb_bus_sel_rr_interconnect.sv
// tb_bus_sel_rr_interconnect
// Directed scenarios on two instances: dut_a with a hold limit of 4 and
// dut_b with unlimited hold. Each stimulus step queues the hand-computed
// owner of every FIFO after the next edge; a monitor pops and compares.
module tb_bus_sel_rr_interconnect;

  localparam int N = 6;
  localparam logic [23:0] IDLE_ALL = 24'hFFFFFF;
  localparam logic [23:0] OWN0_ALL = 24'h000000;

  typedef struct packed {
    logic [23:0] own_a;
    logic [23:0] own_b;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [35:0]   req_a = '0;
  logic [35:0]   req_b = '0;
  logic [35:0]   grant_a, sel_a, grant_b, sel_b;
  logic [5:0]    busy_a, busy_b;
  logic [35:0]   all_req = '1;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  bus_sel_rr_interconnect #(.PORT_NUM(N), .MAX_HOLD(4), .CNT_W(8)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .fd_bus_req   (req_a),
    .fd_bus_grant (grant_a),
    .fifo_bus_sel (sel_a),
    .fifo_busy    (busy_a)
  );

  bus_sel_rr_interconnect #(.PORT_NUM(N), .MAX_HOLD(0), .CNT_W(8)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .fd_bus_req   (req_b),
    .fd_bus_grant (grant_b),
    .fifo_bus_sel (sel_b),
    .fifo_busy    (busy_b)
  );

  always #5 clk = ~clk;

  // Request bit for fd requesting fifo.
  function automatic logic [35:0] rq(input int fd, input int fifo);
    logic [35:0] r;
    r = '0;
    r[fd*N + fifo] = 1'b1;
    return r;
  endfunction

  // Owner table with only one FIFO locked.
  function automatic logic [23:0] one(input int fifo, input int fd);
    logic [23:0] r;
    r = IDLE_ALL;
    r[fifo*4 +: 4] = 4'(fd);
    return r;
  endfunction

  function automatic logic [3:0] nib(input int fd);
    return (fd < 0) ? 4'hF : 4'(fd);
  endfunction

  // Owner table for FIFOs 0..5; -1 means IDLE.
  function automatic logic [23:0] ow(input int f0, input int f1, input int f2,
                                     input int f3, input int f4, input int f5);
    return {nib(f5), nib(f4), nib(f3), nib(f2), nib(f1), nib(f0)};
  endfunction

  task automatic compare(input string name, input logic [35:0] actual,
                         input logic [35:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, required);
    end
  endtask

  // Expand an owner table into grant/sel/busy and compare one instance.
  task automatic check_output(input string tag, input logic [23:0] own,
                              input logic [35:0] g, input logic [35:0] s,
                              input logic [5:0] b);
    logic [35:0] eg, es;
    logic [5:0]  eb;
    logic [3:0]  o;
    eg = '0;
    es = '0;
    eb = '0;
    for (int y = 0; y < N; y++) begin
      o = own[y*4 +: 4];
      if (o != 4'hF) begin
        eg[int'(o)*N + y] = 1'b1;
        es[y*N + int'(o)] = 1'b1;
        eb[y]             = 1'b1;
      end
    end
    compare({tag, "_grant"}, g, eg);
    compare({tag, "_sel"}, s, es);
    compare({tag, "_busy"}, {30'b0, b}, {30'b0, eb});
  endtask

  // Drive one cycle of inputs and queue the owners expected after the edge.
  task automatic apply_stimulus(input logic [35:0] ra, input logic [35:0] rb,
                                input logic r, input logic [23:0] ea,
                                input logic [23:0] eb);
    exp_t e;
    @(negedge clk);
    rst   = r;
    req_a = ra;
    req_b = rb;
    e.own_a = ea;
    e.own_b = eb;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    apply_stimulus('0, '0, 1'b1, IDLE_ALL, IDLE_ALL);
  endtask

  // Monitor: compare both instances shortly after every rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output("a", e.own_a, grant_a, sel_a, busy_a);
      check_output("b", e.own_b, grant_b, sel_b, busy_b);
    end
  end

  logic [35:0] rr_all, rr_no1, rr_no3, rr_no4, pre_req, ind_req;

  initial begin
    // Reset with every request high, then every FIFO goes to fd 0.
    apply_stimulus(all_req, all_req, 1'b1, IDLE_ALL, IDLE_ALL);
    apply_stimulus(all_req, all_req, 1'b1, IDLE_ALL, IDLE_ALL);
    apply_stimulus(all_req, all_req, 1'b0, OWN0_ALL, OWN0_ALL);
    apply_stimulus(all_req, all_req, 1'b0, OWN0_ALL, OWN0_ALL);
    do_reset();

    // Transpose: fd 2 -> FIFO 5 (grant bit 17, sel bit 32, busy 6'b100000).
    apply_stimulus(rq(2, 5), '0, 1'b0, one(5, 2), IDLE_ALL);
    apply_stimulus(rq(2, 5), '0, 1'b0, one(5, 2), IDLE_ALL);
    apply_stimulus('0, '0, 1'b0, IDLE_ALL, IDLE_ALL);
    apply_stimulus('0, '0, 1'b0, IDLE_ALL, IDLE_ALL);
    do_reset();

    // Round-robin on FIFO 0 among fds 1, 3, 4: owners 1, 3, 4, 1.
    rr_all = rq(1, 0) | rq(3, 0) | rq(4, 0);
    rr_no1 = rq(3, 0) | rq(4, 0);
    rr_no3 = rq(1, 0) | rq(4, 0);
    rr_no4 = rq(1, 0) | rq(3, 0);
    apply_stimulus(rr_all, '0, 1'b0, one(0, 1), IDLE_ALL);
    apply_stimulus(rr_no1, '0, 1'b0, IDLE_ALL, IDLE_ALL);
    apply_stimulus(rr_all, '0, 1'b0, one(0, 3), IDLE_ALL);
    apply_stimulus(rr_no3, '0, 1'b0, IDLE_ALL, IDLE_ALL);
    apply_stimulus(rr_all, '0, 1'b0, one(0, 4), IDLE_ALL);
    apply_stimulus(rr_no4, '0, 1'b0, IDLE_ALL, IDLE_ALL);
    apply_stimulus(rr_all, '0, 1'b0, one(0, 1), IDLE_ALL);
    apply_stimulus('0, '0, 1'b0, IDLE_ALL, IDLE_ALL);
    do_reset();

    // Preemption on FIFO 2 between fd 0 and fd 5; dut_b never rotates.
    pre_req = rq(0, 2) | rq(5, 2);
    for (int i = 0; i < 4; i++) apply_stimulus(pre_req, pre_req, 1'b0, one(2, 0), one(2, 0));
    apply_stimulus(pre_req, pre_req, 1'b0, IDLE_ALL, one(2, 0));
    for (int i = 0; i < 4; i++) apply_stimulus(pre_req, pre_req, 1'b0, one(2, 5), one(2, 0));
    apply_stimulus(pre_req, pre_req, 1'b0, IDLE_ALL, one(2, 0));
    apply_stimulus(pre_req, pre_req, 1'b0, one(2, 0), one(2, 0));
    do_reset();

    // Independence: fd 3 on FIFOs 0,1,2 and fd 4 on FIFO 1.
    ind_req = rq(3, 0) | rq(3, 1) | rq(3, 2) | rq(4, 1);
    for (int i = 0; i < 4; i++) apply_stimulus(ind_req, '0, 1'b0, ow(3, 3, 3, -1, -1, -1), IDLE_ALL);
    apply_stimulus(ind_req, '0, 1'b0, ow(3, -1, 3, -1, -1, -1), IDLE_ALL);
    apply_stimulus(ind_req, '0, 1'b0, ow(3, 4, 3, -1, -1, -1), IDLE_ALL);
    apply_stimulus(rq(4, 1), '0, 1'b0, ow(-1, 4, -1, -1, -1, -1), IDLE_ALL);
    apply_stimulus('0, '0, 1'b0, IDLE_ALL, IDLE_ALL);
    do_reset();

    // Reset mid-lock on FIFO 3, then reset clears the rotation pointer.
    apply_stimulus(rq(2, 3), '0, 1'b0, one(3, 2), IDLE_ALL);
    apply_stimulus(rq(2, 3), '0, 1'b1, IDLE_ALL, IDLE_ALL);
    apply_stimulus(rq(2, 3), '0, 1'b0, one(3, 2), IDLE_ALL);
    apply_stimulus('0, '0, 1'b0, IDLE_ALL, IDLE_ALL);
    apply_stimulus('0, '0, 1'b1, IDLE_ALL, IDLE_ALL);
    apply_stimulus(rq(1, 3) | rq(2, 3), '0, 1'b0, one(3, 1), IDLE_ALL);
    apply_stimulus('0, '0, 1'b0, IDLE_ALL, IDLE_ALL);

    // Let the monitor drain the last expectations.
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
